// File: rtl/timed_step_sequencer.sv
// Steps the interval timer through NUM_STEPS steps of a programmable number of timer periods,
// dropping timer_enable for one cycle between steps so the timer restarts from zero.
module timed_step_sequencer #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned STEP_W    = 2,
  parameter int unsigned PER_W     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PER_W-1:0]  periods_per_step,
  input  logic              timer_done,
  output logic              timer_enable,
  output logic [STEP_W-1:0] step,
  output logic [PER_W-1:0]  period_cnt,
  output logic              busy,
  output logic              seq_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FINISH} state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t             state_q, state_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic               done_q;
  logic               en_d, busy_d, sdone_d;
  logic [STEP_W-1:0]  step_d;
  logic [PER_W-1:0]   pcnt_d;
  logic               done_evt_c;

  // Rising edge of timer_done; only meaningful while a step is running
  assign done_evt_c = timer_done & ~done_q & (state_q == S_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      per_q        <= PER_W'(1);
      done_q       <= 1'b0;
      timer_enable <= 1'b0;
      step         <= '0;
      period_cnt   <= '0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      done_q       <= timer_done;
      timer_enable <= en_d;
      step         <= step_d;
      period_cnt   <= pcnt_d;
      busy         <= busy_d;
      seq_done     <= sdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    en_d    = timer_enable;
    step_d  = step;
    pcnt_d  = period_cnt;
    busy_d  = busy;
    sdone_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          per_d   = (periods_per_step == '0) ? PER_W'(1) : periods_per_step;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          step_d  = '0;
          pcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (done_evt_c) begin
          if (period_cnt < per_q - PER_W'(1)) begin
            pcnt_d = period_cnt + PER_W'(1);
          end else if (step < LAST_STEP) begin
            state_d = S_GAP;
            step_d  = step + STEP_W'(1);
            pcnt_d  = '0;
            en_d    = 1'b0;
          end else begin
            state_d = S_FINISH;
            en_d    = 1'b0;
            sdone_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        state_d = S_RUN;
        en_d    = 1'b1;
      end
      S_FINISH: begin
        // step and period_cnt keep their final values for display
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any step or period advance in the same cycle
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      sdone_d = 1'b0;
      step_d  = '0;
      pcnt_d  = '0;
    end
  end

endmodule
